// File: rtl/arm1_pkg.sv
// Shared types and sizing for the memory port arbiter: FSM states,
// requester identifiers and the memory geometry.
package arm1_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters, one access per IDLE->ACCESS->RESP pass.
// Build option ARB_RR_EN: round-robin on ties; otherwise data port has fixed priority over fetch.
module mem_port_arbiter #(
   parameter int ADDR_W = arm1_pkg::ADDR_W,
   parameter int DATA_W = arm1_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   import arm1_pkg::*;

   arb_state_t        state_q, state_d;
   req_id_t           win_q, win_d;
   req_id_t           pick_s;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              busy_q;

`ifdef ARB_RR_EN
   req_id_t           last_q, last_d;
`endif

   // Winner selection among currently asserted requests
   always_comb begin
      pick_s = REQ_DM;
      if (if_req && dm_req) begin
`ifdef ARB_RR_EN
         pick_s = (last_q == REQ_DM) ? REQ_IF : REQ_DM;
`else
         pick_s = REQ_DM;
`endif
      end else if (if_req) begin
         pick_s = REQ_IF;
      end else begin
         pick_s = REQ_DM;
      end
   end

`ifdef ARB_RR_EN
   // Last-served pointer moves only when a grant is made
   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && (if_req || dm_req)) begin
         last_d = pick_s;
      end else begin
         last_d = last_q;
      end
   end

   // Pointer register; reset makes data the first tie winner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= REQ_IF;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Next-state and registered-output computation
   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      if_ack_d      = 1'b0;
      dm_ack_d      = 1'b0;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               state_d = ACCESS;
               win_d   = pick_s;
               if (pick_s == REQ_DM) begin
                  mem_address_d = dm_addr;
                  mem_read_d    = ~dm_we;
                  mem_write_d   = dm_we;
                  mem_wdata_d   = dm_we ? dm_wdata : mem_wdata_q;
               end else begin
                  mem_address_d = if_addr;
                  mem_read_d    = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = RESP;
            // Strobes are registered, so mem_read_q marks a read in this cycle
            if (mem_read_q) begin
               if (win_q == REQ_IF) begin
                  if_rdata_d = mem_rdata;
               end else begin
                  dm_rdata_d = mem_rdata;
               end
            end else begin
               if_rdata_d = if_rdata_q;
            end
            if_ack_d = (win_q == REQ_IF);
            dm_ack_d = (win_q == REQ_DM);
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; async reset also kills an in-flight write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         win_q         <= REQ_IF;
         mem_address_q <= {ADDR_W{1'b0}};
         mem_wdata_q   <= {DATA_W{1'b0}};
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         if_ack_q      <= 1'b0;
         dm_ack_q      <= 1'b0;
         if_rdata_q    <= {DATA_W{1'b0}};
         dm_rdata_q    <= {DATA_W{1'b0}};
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         if_ack_q      <= if_ack_d;
         dm_ack_q      <= dm_ack_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         busy_q        <= (state_d != IDLE);
      end
   end

   assign if_ack      = if_ack_q;
   assign dm_ack      = dm_ack_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign mem_address = mem_address_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 16x8 memory.
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       if_req, dm_req, dm_we;
   logic [3:0] if_addr, dm_addr;
   logic [7:0] dm_wdata;
   logic       if_ack, dm_ack, mem_read, mem_write, busy;
   logic [7:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_address;
   logic       preload;
   logic [7:0] mem [16];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   assign mem_rdata = mem[mem_address];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         mem[0]  <= 8'hCC;
         mem[1]  <= 8'hDD;
         mem[12] <= 8'h05;
         mem[13] <= 8'h03;
      end else if (mem_write) begin
         mem[mem_address] <= mem_wdata;
      end
   end

   typedef struct {
      logic       if_req;
      logic [3:0] if_addr;
      logic       dm_req;
      logic       dm_we;
      logic [3:0] dm_addr;
      logic [7:0] dm_wdata;
      int         exp_if_cyc;
      int         exp_dm_cyc;
      int         exp_wr;
      int         exp_rd;
      logic [7:0] exp_if_q;
      logic [7:0] exp_dm_q;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int if_cyc, dm_cyc, wr_cnt, rd_cnt;
      logic [7:0] if_d, dm_d;
      if_cyc = 0; dm_cyc = 0; wr_cnt = 0; rd_cnt = 0;
      if_d = 8'h00; dm_d = 8'h00;
      @(negedge clk);
      if_req = v.if_req; if_addr = v.if_addr;
      dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
         if (mem_write) wr_cnt++;
         if (mem_read) rd_cnt++;
         if (if_ack) begin if_cyc = c; if_d = if_rdata; if_req = 1'b0; end
         if (dm_ack) begin dm_cyc = c; dm_d = dm_rdata; dm_req = 1'b0; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      check($sformatf("v%0d_if_ack_cyc", idx), if_cyc, v.exp_if_cyc);
      check($sformatf("v%0d_dm_ack_cyc", idx), dm_cyc, v.exp_dm_cyc);
      check($sformatf("v%0d_wr_cycles", idx), wr_cnt, v.exp_wr);
      check($sformatf("v%0d_rd_cycles", idx), rd_cnt, v.exp_rd);
      if (v.exp_if_cyc != 0) check($sformatf("v%0d_if_data", idx), {24'd0, if_d}, {24'd0, v.exp_if_q});
      if (v.exp_dm_cyc != 0 && !v.dm_we) check($sformatf("v%0d_dm_data", idx), {24'd0, dm_d}, {24'd0, v.exp_dm_q});
      check($sformatf("v%0d_if_rdata_hold", idx), {24'd0, if_rdata}, {24'd0, v.exp_if_q});
      check($sformatf("v%0d_dm_rdata_hold", idx), {24'd0, dm_rdata}, {24'd0, v.exp_dm_q});
      check($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int ack_seen;
      int nack;
      int acyc [5];
      logic [7:0] adat [5];
      logic [3:0] b2b_addr [5];
      logic [7:0] b2b_exp [5];

      //                if  ia     dm  we  da     wd      ifc dmc wr rd  if_q   dm_q
      vecs[0] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  8'h00, 2, 0, 0, 1, 8'hCC, 8'h00};
      vecs[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 8'h00, 0, 2, 0, 1, 8'hCC, 8'h05};
      vecs[2] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd14, 8'h08, 0, 2, 1, 0, 8'hCC, 8'h05};
      vecs[3] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd14, 8'h00, 0, 2, 0, 1, 8'hCC, 8'h08};
`ifdef ARB_RR_EN
      vecs[4] = '{1'b1, 4'd1,  1'b1, 1'b0, 4'd13, 8'h00, 2, 5, 0, 2, 8'hDD, 8'h03};
      vecs[5] = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd12, 8'h00, 2, 5, 0, 2, 8'hCC, 8'h05};
`else
      vecs[4] = '{1'b1, 4'd1,  1'b1, 1'b0, 4'd13, 8'h00, 5, 2, 0, 2, 8'hDD, 8'h03};
      vecs[5] = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd12, 8'h00, 5, 2, 0, 2, 8'hCC, 8'h05};
`endif
      vecs[6] = '{1'b1, 4'd13, 1'b0, 1'b0, 4'd0,  8'h00, 2, 0, 0, 1, 8'h03, 8'h05};
      vecs[7] = '{1'b1, 4'd1,  1'b1, 1'b0, 4'd0,  8'h00, 5, 2, 0, 2, 8'hDD, 8'hCC};
      vecs[8] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  8'h5A, 0, 2, 1, 0, 8'hDD, 8'hCC};
      vecs[9] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  8'h00, 2, 0, 0, 1, 8'h5A, 8'hCC};

      b2b_addr = '{4'd0, 4'd1, 4'd12, 4'd13, 4'd3};
      b2b_exp  = '{8'h5A, 8'hDD, 8'h05, 8'h03, 8'h00};

      rst_n = 1'b0; preload = 1'b1;
      if_req = 1'b0; if_addr = 4'd0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 4'd0; dm_wdata = 8'h00;
      repeat (3) @(negedge clk);
      preload = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
      check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_rdata", {16'd0, if_rdata, dm_rdata}, 32'd0);
      check("rst_mem_out", {20'd0, mem_address, mem_wdata}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

      // Reset in the middle of a write access
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 4'd3; dm_wdata = 8'h77;
      @(negedge clk);
      check("rstmid_write_active", {31'd0, mem_write}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_write_drop", {31'd0, mem_write}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_ack", {30'd0, if_ack, dm_ack}, 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ack_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (if_ack || dm_ack || busy) ack_seen = 1;
      end
      check("rstmid_no_ack", ack_seen, 0);

      // Back-to-back fetches with if_req held and address advanced at each ack
      nack = 0;
      @(negedge clk);
      if_req = 1'b1; if_addr = b2b_addr[0];
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (if_ack && nack < 5) begin
            acyc[nack] = c;
            adat[nack] = if_rdata;
            nack++;
            if (nack < 5) if_addr = b2b_addr[nack];
            else if_req = 1'b0;
         end
      end
      if_req = 1'b0;
      check("b2b_count", nack, 5);
      for (int k = 0; k < nack; k++) begin
         check($sformatf("b2b_cyc%0d", k), acyc[k], 2 + 3 * k);
         check($sformatf("b2b_data%0d", k), {24'd0, adat[k]}, {24'd0, b2b_exp[k]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
